jk_cmd_gen: RTL
===============

# jk_cmd_gen

Upstream command stage for the JK flip-flop. Two raw push-button inputs go through synchronizers, debouncers and a pairing state machine, and come out as single-cycle J/K strobes. A press of the set button yields a J strobe, and a press of the clear button yields a K strobe. Pressing both within a short window yields a J=K=1 toggle strobe, so the downstream flip-flop sees exactly one command per physical press.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required before a debounced level changes; legal range 2..65535.
- `PAIR_WINDOW`, 8: cycles to wait for the partner button after a single press; legal range 1..255.
- `REPEAT_DELAY`, 256: cycles from a strobe to the first auto-repeat. Used only with `JK_CMD_GEN_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 64: cycles between later auto-repeats. Used only with `JK_CMD_GEN_AUTOREPEAT_EN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_set_raw` input 1: asynchronous set button, active-high.
- `btn_clr_raw` input 1: asynchronous clear button, active-high.
- `J` output 1: registered J strobe for the flip-flop.
- `K` output 1: registered K strobe for the flip-flop.
- `set_lvl` output 1: debounced set-button level.
- `clr_lvl` output 1: debounced clear-button level.

## Operation
- **Reset.** While `rst` is sampled high, every flop clears: synchronizers, debounce counters, levels, FSM and outputs.
  - `J`, `K`, `set_lvl` and `clr_lvl` all read 0.
  - FSM returns to IDLE.
  - A button held through reset release is debounced again and produces a press.
- **Synchronizer.** Each raw input passes through two flops.
- **Debounce, per channel.**
  - The counter increments on every cycle where the synchronized value differs from the level, and clears on any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the level takes the synchronized value and the counter clears.
  - A counter of width ceil(log2(`DEBOUNCE_CYCLES`+1)) bits cannot wrap.
- **Press.** Asserted for one cycle on a rising edge of the debounced level. Releases generate nothing.
- **FSM states and transitions.**
  - IDLE, both presses in the same cycle: emit toggle, stay in IDLE.
  - IDLE, set press only: go to PAIR_S, window counter = 0.
  - IDLE, clear press only: go to PAIR_C, window counter = 0.
  - PAIR_S, clear press arrives: emit toggle, go to IDLE.
  - PAIR_S, window counter reaches `PAIR_WINDOW`: emit J only, go to IDLE.
  - PAIR_S, a further set press: ignored.
  - PAIR_C: mirror of PAIR_S, emitting K only on timeout.
  - A partner press in the same cycle as window expiry counts as a pair, so the toggle wins.
- **Emit.** On the next edge, drive `J` and/or `K` high for exactly one cycle. `J` and `K` are never high on two consecutive cycles.
- **Strobe rate.** At most one strobe per press event.

## Timing
- Raw input step at edge 0, held stable:
  - Synchronized value is valid after edge 1.
  - Debounced level rises after edge 1+`DEBOUNCE_CYCLES`.
  - Press is high during the following cycle.
- Both buttons stepping at the same edge: `J`=`K`=1 for exactly one cycle, after edge 2+`DEBOUNCE_CYCLES`.
- Single press: the strobe is high for one cycle after edge 2+`DEBOUNCE_CYCLES`+`PAIR_WINDOW`.
- Partner press arriving k cycles after the first (k ≤ `PAIR_WINDOW`): toggle strobe after the edge at which the partner press is sampled.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no level change and no strobe.
- `rst` asserted mid-window or mid-strobe: outputs read 0 after that edge; no pending command survives.

## Configuration
- **Macro `JK_CMD_GEN_AUTOREPEAT_EN`.**
- **Defined:** a HOLD state is compiled in.
  - After any strobe, the FSM enters HOLD while the originating debounced level(s) stay at 1.
  - The first repeat strobe is emitted `REPEAT_DELAY` cycles after the original. Later repeats follow every `REPEAT_PERIOD` cycles.
  - Each repeat has the same J/K pattern as the original strobe.
  - Any originating level falling returns the FSM to IDLE, with no strobe on that edge.
  - Presses arriving during HOLD are ignored.
- **Undefined:** no HOLD state and no repeat counters. A new strobe requires release and re-press, and the `REPEAT_*` parameters are unused.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `PAIR_WINDOW`=3.

1. Reset: hold `rst`=1 for 3 cycles with both buttons at 1, then release → `J`=`K`=0 throughout reset; `set_lvl`=`clr_lvl`=1 after edge 5 post-release; then one toggle strobe.
2. Set button steps 0→1 at edge 0 and is held → `J`=1, `K`=0 for one cycle only, after edge 9; no further strobes.
3. Clear button steps at edge 0, set button steps at edge 2 → exactly one `J`=`K`=1 cycle, after edge 8; no separate `K` strobe.
4. Set button pulsed high for 3 cycles, with bounce 1-0-1-0 → `set_lvl` stays 0; `J`=0 throughout.
5. `rst` asserted at edge 7 during PAIR_S from scenario 2 → no `J` strobe ever appears; FSM in IDLE.
6. With the macro defined, `REPEAT_DELAY`=20 and `REPEAT_PERIOD`=5, set button held → `J` strobes at edges 9, 29, 34, 39…; releasing stops strobes with no extra pulse.

Source files
------------

// File: rtl/jk_cmd_gen.sv
// jk_cmd_gen: synchronizes and debounces two push-buttons, then pairs presses into single-cycle J/K strobes.
// Optional auto-repeat while held is compiled in when JK_CMD_GEN_AUTOREPEAT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a press
// PAIR_S | set pressed, waiting for a clear partner or window expiry
// PAIR_C | clear pressed, waiting for a set partner or window expiry
// HOLD   | auto-repeat build only: repeating the last strobe while its button(s) stay held
module jk_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PAIR_WINDOW     = 8,
  parameter int REPEAT_DELAY    = 256,
  parameter int REPEAT_PERIOD   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set_raw,
  input  logic btn_clr_raw,
  output logic J,
  output logic K,
  output logic set_lvl,
  output logic clr_lvl
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(PAIR_WINDOW + 1);
  localparam logic [DW-1:0] DB_N  = DW'(DEBOUNCE_CYCLES);
  localparam logic [WW-1:0] WIN_N = WW'(PAIR_WINDOW);

  typedef enum logic [1:0] {
    IDLE,
    PAIR_S,
`ifdef JK_CMD_GEN_AUTOREPEAT_EN
    PAIR_C,
    HOLD
`else
    PAIR_C
`endif
  } state_t;

  // Bit 0 is the set channel, bit 1 the clear channel.
  logic [1:0]         meta_q, meta_d, sync_q, sync_d;
  logic [1:0]         lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  state_t             state_q, state_d;
  logic [WW-1:0]      win_q, win_d, win_inc;
  logic               j_q, j_d, k_q, k_d;
  logic               press_s, press_c;

`ifdef JK_CMD_GEN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_DLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_PER = RW'(REPEAT_PERIOD);
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  logic          first_q, first_d;
  logic [1:0]    pat_q, pat_d;
`endif

  always_comb begin
    meta_d     = {btn_clr_raw, btn_set_raw};
    sync_d     = meta_q;
    lvl_prev_d = lvl_q;
    lvl_d      = lvl_q;
    db_cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] + DW'(1) == DB_N) lvl_d[i] = sync_q[i];
        else                              db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
    end
  end

  assign press_s = lvl_q[0] & ~lvl_prev_q[0];
  assign press_c = lvl_q[1] & ~lvl_prev_q[1];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    win_inc = win_q + WW'(1);
    j_d     = 1'b0;
    k_d     = 1'b0;
`ifdef JK_CMD_GEN_AUTOREPEAT_EN
    rep_d   = rep_q;
    rep_inc = rep_q + RW'(1);
    first_d = first_q;
    pat_d   = pat_q;
`endif
    case (state_q)
      IDLE: begin
        if (press_s && press_c) begin
          j_d = 1'b1;
          k_d = 1'b1;
        end else if (press_s) begin
          state_d = PAIR_S;
          win_d   = '0;
        end else if (press_c) begin
          state_d = PAIR_C;
          win_d   = '0;
        end
      end
      // Partner is tested before expiry so a same-cycle partner still pairs.
      PAIR_S: begin
        if (press_c) begin
          j_d     = 1'b1;
          k_d     = 1'b1;
          state_d = IDLE;
        end else if (win_inc == WIN_N) begin
          j_d     = 1'b1;
          state_d = IDLE;
        end else begin
          win_d = win_inc;
        end
      end
      PAIR_C: begin
        if (press_s) begin
          j_d     = 1'b1;
          k_d     = 1'b1;
          state_d = IDLE;
        end else if (win_inc == WIN_N) begin
          k_d     = 1'b1;
          state_d = IDLE;
        end else begin
          win_d = win_inc;
        end
      end
`ifdef JK_CMD_GEN_AUTOREPEAT_EN
      HOLD: begin
        if ((pat_q[1] & ~lvl_q[0]) | (pat_q[0] & ~lvl_q[1])) begin
          state_d = IDLE;
        end else if (rep_inc == (first_q ? REP_DLY : REP_PER)) begin
          j_d     = pat_q[1];
          k_d     = pat_q[0];
          rep_d   = '0;
          first_d = 1'b0;
        end else begin
          rep_d = rep_inc;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef JK_CMD_GEN_AUTOREPEAT_EN
    // A fresh strobe arms HOLD only if every originating button is still down.
    if ((state_q != HOLD) && (j_d || k_d) && (!j_d || lvl_q[0]) && (!k_d || lvl_q[1])) begin
      state_d = HOLD;
      pat_d   = {j_d, k_d};
      rep_d   = '0;
      first_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      win_q      <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
`ifdef JK_CMD_GEN_AUTOREPEAT_EN
      rep_q      <= '0;
      first_q    <= 1'b0;
      pat_q      <= '0;
`endif
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      win_q      <= win_d;
      j_q        <= j_d;
      k_q        <= k_d;
`ifdef JK_CMD_GEN_AUTOREPEAT_EN
      rep_q      <= rep_d;
      first_q    <= first_d;
      pat_q      <= pat_d;
`endif
    end
  end

  assign J       = j_q;
  assign K       = k_q;
  assign set_lvl = lvl_q[0];
  assign clr_lvl = lvl_q[1];

endmodule
